// File: rtl/count_mode_sequencer.sv
// rtl/count_mode_sequencer.sv - replays a programmed {mode,len} step list into the BCD counter datapath
module count_mode_sequencer #(
  parameter int SLOTS = 4,
  parameter int LEN_W = 3
) (
  input  logic                     KEY0,
  input  logic                     SW0,
  input  logic                     prog_wr,
  input  logic [LEN_W+1:0]         prog_data,
  input  logic                     run,
  input  logic                     loop,
  input  logic                     hold,
  output logic [1:0]               mode_out,
  output logic                     step_en,
  output logic [$clog2(SLOTS)-1:0] slot_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = $clog2(SLOTS);
  localparam int NW = $clog2(SLOTS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [LEN_W+1:0]  slots_q [SLOTS];
  logic [IW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [NW-1:0]     n_loaded_q, n_loaded_d;
  logic [IW-1:0]     slot_idx_q, slot_idx_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              step_en_q, step_en_d;
  logic              wr_en;

  logic              first_found, next_found;
  logic [IW-1:0]     first_idx, next_idx;

  // Zero-length slots are skipped by searching only for loaded, non-empty entries.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (NW'(i) < n_loaded_q && slots_q[i][LEN_W-1:0] != '0) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = IW'(i);
        end
        if (!next_found && NW'(i) > NW'(slot_idx_q)) begin
          next_found = 1'b1;
          next_idx   = IW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    n_loaded_d = n_loaded_q;
    slot_idx_d = slot_idx_q;
    cnt_d      = cnt_q;
    mode_d     = 2'b00;
    step_en_d  = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (prog_wr) begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + IW'(1);
          n_loaded_d = (n_loaded_q == NW'(SLOTS)) ? n_loaded_q : n_loaded_q + NW'(1);
        end else if (run) begin
          if (first_found) begin
            state_d    = S_RUN;
            slot_idx_d = first_idx;
            cnt_d      = slots_q[first_idx][LEN_W-1:0];
            mode_d     = slots_q[first_idx][LEN_W+1:LEN_W];
            step_en_d  = ~hold;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (step_en_q && cnt_q == LEN_W'(1)) begin
          // Last step of this slot is going out now; line up the next slot with no gap.
          if (next_found) begin
            slot_idx_d = next_idx;
            cnt_d      = slots_q[next_idx][LEN_W-1:0];
            mode_d     = slots_q[next_idx][LEN_W+1:LEN_W];
            step_en_d  = ~hold;
          end else if (loop) begin
            slot_idx_d = first_idx;
            cnt_d      = slots_q[first_idx][LEN_W-1:0];
            mode_d     = slots_q[first_idx][LEN_W+1:LEN_W];
            step_en_d  = ~hold;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          if (step_en_q) cnt_d = cnt_q - LEN_W'(1);
          mode_d    = mode_q;
          step_en_d = ~hold;
        end
      end
      S_DONE: begin
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge KEY0) begin
    if (!SW0) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      n_loaded_q <= '0;
      slot_idx_q <= '0;
      cnt_q      <= '0;
      mode_q     <= 2'b00;
      step_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      n_loaded_q <= n_loaded_d;
      slot_idx_q <= slot_idx_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      step_en_q  <= step_en_d;
    end
  end

  always_ff @(negedge KEY0) begin
    if (SW0 && wr_en) slots_q[wr_ptr_q] <= prog_data;
  end

  assign mode_out = mode_q;
  assign step_en  = step_en_q;
  assign slot_idx = slot_idx_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_count_mode_sequencer.sv
// tb/tb_count_mode_sequencer.sv - directed self-checking bench for count_mode_sequencer
module tb_count_mode_sequencer;

  logic       KEY0 = 1'b1;
  logic       SW0 = 1'b0;
  logic       prog_wr = 1'b0;
  logic [4:0] prog_data = '0;
  logic       run = 1'b0;
  logic       loop = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] mode_out;
  logic       step_en;
  logic [1:0] slot_idx;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;
  int ctr = 0;
  int pulses = 0;

  int exp2_mode[5] = '{2, 2, 2, 3, 3};
  int exp2_slot[5] = '{0, 0, 0, 1, 1};
  int exp3_mode[3] = '{1, 1, 2};
  int exp3_slot[3] = '{0, 0, 2};
  int exp5_mode[5] = '{3, 3, 2, 2, 2};
  int exp5_slot[5] = '{0, 0, 1, 2, 3};

  count_mode_sequencer #(.SLOTS(4), .LEN_W(3)) dut (
    .KEY0(KEY0), .SW0(SW0), .prog_wr(prog_wr), .prog_data(prog_data),
    .run(run), .loop(loop), .hold(hold), .mode_out(mode_out),
    .step_en(step_en), .slot_idx(slot_idx), .busy(busy), .done(done)
  );

  always #5 KEY0 = ~KEY0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample 1 time unit after the active (falling) edge; fold any issued step into the counter model.
  task automatic tick();
    @(negedge KEY0);
    #1;
    if (step_en === 1'b1) begin
      pulses++;
      case (mode_out)
        2'b10: ctr = (ctr + 1) % 10;
        2'b01: ctr = (ctr + 2) % 10;
        2'b11: ctr = (ctr + 9) % 10;
        default: ;
      endcase
    end
  endtask

  task automatic load(input logic [4:0] d);
    prog_wr = 1'b1;
    prog_data = d;
    tick();
    prog_wr = 1'b0;
  endtask

  task automatic do_reset();
    SW0 = 1'b0;
    run = 1'b0;
    hold = 1'b0;
    loop = 1'b0;
    tick();
    SW0 = 1'b1;
    ctr = 0;
    pulses = 0;
  endtask

  initial begin
    // 1: reset dominates run; run with empty program goes straight to DONE
    SW0 = 1'b0; run = 1'b1;
    tick();
    check("rst_mode", mode_out, 0);
    check("rst_en", step_en, 0);
    check("rst_slot", slot_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    SW0 = 1'b1;
    tick();
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);
    run = 1'b0;
    tick();
    check("done_exit", done, 0);

    // 2: {10,3},{11,2} single pass
    do_reset();
    load(5'b10_011);
    load(5'b11_010);
    run = 1'b1; loop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_en", step_en, 1);
      check("t2_mode", mode_out, exp2_mode[k]);
      check("t2_slot", slot_idx, exp2_slot[k]);
      check("t2_busy", busy, 1);
      if (k == 2) check("t2_ctr_mid", ctr, 3);
    end
    tick();
    check("t2_done", done, 1);
    check("t2_en_off", step_en, 0);
    check("t2_mode_off", mode_out, 0);
    check("t2_ctr_end", ctr, 1);
    check("t2_pulses", pulses, 5);
    run = 1'b0;
    tick();

    // 3: zero-length slot skipped, looping, write+run on same edge defers run
    do_reset();
    load(5'b01_010);
    load(5'b00_000);
    prog_wr = 1'b1; prog_data = 5'b10_001; run = 1'b1; loop = 1'b1;
    tick();
    prog_wr = 1'b0;
    check("t3_defer", busy, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t3_en", step_en, 1);
      check("t3_mode", mode_out, exp3_mode[k % 3]);
      check("t3_slot", slot_idx, exp3_slot[k % 3]);
    end
    run = 1'b0;
    tick();
    check("t3_stop_busy", busy, 0);
    check("t3_stop_en", step_en, 0);

    // 4: hold mid-slot freezes progress, total pulses unchanged
    do_reset();
    load(5'b10_011);
    load(5'b01_010);
    run = 1'b1; loop = 1'b0;
    tick();
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_hold_en", step_en, 0);
      check("t4_hold_slot", slot_idx, 0);
      check("t4_hold_mode", mode_out, 2);
    end
    hold = 1'b0;
    for (int k = 0; k < 20 && done !== 1'b1; k++) tick();
    check("t4_done", done, 1);
    check("t4_pulses", pulses, 5);
    check("t4_ctr", ctr, 7);
    run = 1'b0;
    tick();

    // 5: fifth write wraps onto slot 0
    do_reset();
    for (int k = 0; k < 4; k++) load(5'b10_001);
    load(5'b11_010);
    run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_en", step_en, 1);
      check("t5_mode", mode_out, exp5_mode[k]);
      check("t5_slot", slot_idx, exp5_slot[k]);
    end
    tick();
    check("t5_done", done, 1);
    check("t5_ctr", ctr, 1);
    run = 1'b0;
    tick();

    // 6: reset mid-run clears program and stops steps immediately
    do_reset();
    load(5'b10_011);
    run = 1'b1;
    tick();
    tick();
    check("t6_step2", step_en, 1);
    SW0 = 1'b0;
    tick();
    check("t6_rst_en", step_en, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_mode", mode_out, 0);
    SW0 = 1'b1;
    tick();
    check("t6_run_en", step_en, 0);
    check("t6_run_busy", busy, 0);
    check("t6_run_done", done, 1);
    run = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
